// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - byte-wide memory bus between the load/store unit and memory
//
// Purpose: carries one byte beat at a time from the load/store unit (master)
// to a byte-addressed memory (slave).
// Signals:
//   memAddr  [ADDR_W] master->slave  byte address of the current beat
//   memWData [8]      master->slave  byte written on a store beat
//   memRe    [1]      master->slave  read strobe
//   memWe    [1]      master->slave  write strobe
//   memRData [8]      slave->master  byte returned for a read beat
//   memReady [1]      slave->master  beat acknowledge, sampled on the rising edge
interface load_store_unit_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] memAddr;
  logic [7:0]        memWData;
  logic              memRe;
  logic              memWe;
  logic [7:0]        memRData;
  logic              memReady;

  modport master (
    output memAddr,
    output memWData,
    output memRe,
    output memWe,
    input  memRData,
    input  memReady
  );

  modport slave (
    input  memAddr,
    input  memWData,
    input  memRe,
    input  memWe,
    output memRData,
    output memReady
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte-serial big-endian load/store unit
//
// Purpose: splits a CPU byte/halfword/word access into 1, 2 or 4 byte beats
// on a byte-wide memory bus, most significant byte first, and assembles and
// sign/zero-extends load results.
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   address [ADDR_W]          CPU byte address
//   writeData [32]            store data, right-justified
//   memRead, memWrite         load / store request (exactly one must be high)
//   size [2]                  00 byte, 01 halfword, 10 word, 11 illegal
//   loadSigned                sign-extend byte/halfword loads
//   readData [32]             last completed load result
//   busy, done, err           in-progress flag, completion pulse, reject pulse
//   mem                       byte memory bus (master side)
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       writeData,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [1:0]        size,
  input  logic              loadSigned,
  output logic [31:0]       readData,
  output logic              busy,
  output logic              done,
  output logic              err,
  load_store_unit_if.master mem
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;

  state_t      state;
  logic [1:0]  beats_left;
  logic        is_load;
  logic        signed_q;
  logic [1:0]  size_q;
  logic [23:0] asm_q;   // bytes received so far, shifted up as each new byte arrives
  logic [23:0] wsh_q;   // store bytes still to send, next one in [23:16]

  logic        req_one;
  logic        misaligned;
  logic        reject;
  logic [31:0] aligned;
  logic [1:0]  first_left;
  logic        beat_done;
  logic [31:0] assembled;
  logic [31:0] load_result;

  always_comb begin
    req_one    = memRead ^ memWrite;
    misaligned = ((size == 2'b01) && address[0]) ||
                 ((size == 2'b10) && (address[1:0] != 2'b00));
    reject     = (memRead && memWrite) || (req_one && ((size == 2'b11) || misaligned));

    // Left-justify the store bytes so beat 0 always takes the top byte.
    case (size)
      2'b00: begin
        aligned    = {writeData[7:0], 24'h0};
        first_left = 2'd0;
      end
      2'b01: begin
        aligned    = {writeData[15:0], 16'h0};
        first_left = 2'd1;
      end
      default: begin
        aligned    = writeData;
        first_left = 2'd3;
      end
    endcase

    beat_done = (state == ACCESS) && mem.memReady && (mem.memRe || mem.memWe);

    // Big-endian: earlier beats end up in more significant positions.
    assembled = {asm_q, mem.memRData};
    case (size_q)
      2'b00:   load_result = {{24{signed_q & assembled[7]}}, assembled[7:0]};
      2'b01:   load_result = {{16{signed_q & assembled[15]}}, assembled[15:0]};
      default: load_result = assembled;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      beats_left   <= 2'd0;
      is_load      <= 1'b0;
      signed_q     <= 1'b0;
      size_q       <= 2'b00;
      asm_q        <= 24'h0;
      wsh_q        <= 24'h0;
      readData     <= 32'h0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      mem.memAddr  <= '0;
      mem.memWData <= 8'h0;
      mem.memRe    <= 1'b0;
      mem.memWe    <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (reject) begin
            state <= ERR;
            err   <= 1'b1;
          end else if (req_one) begin
            state        <= ACCESS;
            busy         <= 1'b1;
            is_load      <= memRead;
            signed_q     <= loadSigned;
            size_q       <= size;
            beats_left   <= first_left;
            asm_q        <= 24'h0;
            wsh_q        <= aligned[23:0];
            mem.memAddr  <= address;
            mem.memWData <= aligned[31:24];
            mem.memRe    <= memRead;
            mem.memWe    <= memWrite;
          end
        end
        ACCESS: begin
          if (beat_done) begin
            asm_q <= assembled[23:0];
            if (beats_left == 2'd0) begin
              state     <= DONE;
              done      <= 1'b1;
              mem.memRe <= 1'b0;
              mem.memWe <= 1'b0;
              if (is_load) begin
                readData <= load_result;
              end
            end else begin
              beats_left   <= beats_left - 2'd1;
              mem.memAddr  <= mem.memAddr + ADDR_W'(1);
              mem.memWData <= wsh_q[23:16];
              wsh_q        <= {wsh_q[15:0], 8'h0};
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        ERR: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
module tb_load_store_unit;
  localparam int ADDR_W = 32;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] address;
  logic [31:0] writeData;
  logic        memRead;
  logic        memWrite;
  logic [1:0]  size;
  logic        loadSigned;
  logic [31:0] readData;
  logic        busy;
  logic        done;
  logic        err;

  load_store_unit_if #(.ADDR_W(ADDR_W)) mem_if ();

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .address    (address),
    .writeData  (writeData),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .size       (size),
    .loadSigned (loadSigned),
    .readData   (readData),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .mem        (mem_if.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Memory slave and bus monitor
  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
  } beat_t;

  logic [7:0]  mem_arr [256];
  logic [7:0]  ref_mem [256];
  beat_t       beats [$];
  beat_t       bt;
  int          beat_count = 0;
  int          stall_cycles = 0;
  int          strobe_cnt = 0;
  logic        hold_prev = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  logic [7:0]  prev_data = 8'h0;
  logic        prev_re = 1'b0;
  logic        prev_we = 1'b0;
  logic        ready_base = 1'b1;
  logic        rand_ready = 1'b0;
  logic        stall_en = 1'b0;
  int          stall_base = 0;
  int          stall_cyc_base = 0;

  assign mem_if.memRData = mem_arr[mem_if.memAddr[7:0]];
  assign mem_if.memReady = ready_base &&
      !(stall_en && ((beat_count - stall_base) == 1) && ((stall_cycles - stall_cyc_base) < 3));

  always @(posedge clk) begin
    if (mem_if.memRe || mem_if.memWe) begin
      strobe_cnt <= strobe_cnt + 1;
      if (hold_prev) begin
        chk("hold_addr", mem_if.memAddr, prev_addr);
        chk("hold_wdata", mem_if.memWData, prev_data);
        chk("hold_strobe", {mem_if.memRe, mem_if.memWe}, {prev_re, prev_we});
      end
      if (mem_if.memReady) begin
        bt.addr = mem_if.memAddr;
        bt.data = mem_if.memWData;
        beats.push_back(bt);
        beat_count <= beat_count + 1;
        if (mem_if.memWe) mem_arr[mem_if.memAddr[7:0]] = mem_if.memWData;
      end else begin
        stall_cycles <= stall_cycles + 1;
      end
      hold_prev <= !mem_if.memReady;
      prev_addr <= mem_if.memAddr;
      prev_data <= mem_if.memWData;
      prev_re   <= mem_if.memRe;
      prev_we   <= mem_if.memWe;
    end else begin
      hold_prev <= 1'b0;
    end
  end

  // Reference rules
  function automatic int nbeats(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : ((sz == 2'b01) ? 2 : 4);
  endfunction

  function automatic logic rejected(input logic [31:0] a, input logic rd, input logic wr,
                                    input logic [1:0] sz);
    if (rd && wr) return 1'b1;
    if (sz == 2'b11) return 1'b1;
    if (sz == 2'b01 && (a % 2) != 0) return 1'b1;
    if (sz == 2'b10 && (a % 4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  // Presents one request, scrambles the inputs while the unit is busy, and
  // returns the cycle (request cycle = 1) on which done or err appeared.
  task automatic run_op(input logic [31:0] a, input logic [31:0] wd, input logic rd,
                        input logic wr, input logic [1:0] sz, input logic sg,
                        output int cyc, output logic gd, output logic ge, output logic b2);
    @(negedge clk);
    address = a; writeData = wd; memRead = rd; memWrite = wr; size = sz; loadSigned = sg;
    cyc = 1; gd = 1'b0; ge = 1'b0; b2 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cyc++;
      if (rand_ready) ready_base = ($urandom_range(0, 3) != 0);
      if (i == 0) b2 = busy;
      if (done) gd = 1'b1;
      if (err) ge = 1'b1;
      if (gd || ge) break;
      address = $urandom; writeData = $urandom;
      memRead = 1'($urandom_range(0, 1)); memWrite = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3)); loadSigned = 1'($urandom_range(0, 1));
    end
    if (!gd && !ge) begin
      checks++; errors++;
      $display("FAIL op_timeout actual=none required=done_or_err");
    end
    memRead = 1'b0; memWrite = 1'b0;
    @(negedge clk);
    chk("pulse_done_low", done, 1'b0);
    chk("pulse_err_low", err, 1'b0);
    chk("idle_busy_low", busy, 1'b0);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wd;
    logic        rd;
    logic        wr;
    logic [1:0]  sz;
    logic        sg;
    logic        exp_err;
    logic [31:0] exp_rd;
    int          exp_cyc;
  } vec_t;

  vec_t        tbl [8];
  int          cyc, b0, s0, nb, ot;
  logic        gd, ge, b2, rd, wr, sg, ee;
  logic [1:0]  sz;
  logic [31:0] a, wd, v, ak, exp_rd;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; address = 0; writeData = 0; memRead = 0; memWrite = 0; size = 0; loadSigned = 0;
    for (int i = 0; i < 256; i++) mem_arr[i] = 8'h0;
    #3;
    chk("rst_readData", readData, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_memAddr", mem_if.memAddr, 32'h0);
    chk("rst_memWData", mem_if.memWData, 8'h0);
    chk("rst_memRe", mem_if.memRe, 1'b0);
    chk("rst_memWe", mem_if.memWe, 1'b0);
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;

    // Directed vectors
    mem_arr[8'h10] = 8'h00; mem_arr[8'h11] = 8'h00; mem_arr[8'h12] = 8'h00; mem_arr[8'h13] = 8'h05;
    mem_arr[8'h21] = 8'h85;
    tbl[0] = '{32'h10, 32'h0,        1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'h00000005, 6};
    tbl[1] = '{32'h21, 32'h0,        1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 32'hFFFFFF85, 3};
    tbl[2] = '{32'h21, 32'h0,        1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h00000085, 3};
    tbl[3] = '{32'h08, 32'hABCD1234, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 32'h00000085, 4};
    tbl[4] = '{32'h02, 32'h0,        1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'h00000085, 2};
    tbl[5] = '{32'h03, 32'h0,        1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 32'h00000085, 2};
    tbl[6] = '{32'h10, 32'h0,        1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 32'h00000085, 2};
    tbl[7] = '{32'h20, 32'h0,        1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 32'h00000085, 2};
    for (int i = 0; i < 8; i++) begin
      b0 = beats.size(); s0 = strobe_cnt;
      run_op(tbl[i].addr, tbl[i].wd, tbl[i].rd, tbl[i].wr, tbl[i].sz, tbl[i].sg, cyc, gd, ge, b2);
      chk($sformatf("v%0d_err", i), ge, tbl[i].exp_err);
      chk($sformatf("v%0d_done", i), gd, !tbl[i].exp_err);
      chk($sformatf("v%0d_readData", i), readData, tbl[i].exp_rd);
      chk($sformatf("v%0d_cycle", i), cyc, tbl[i].exp_cyc);
      chk($sformatf("v%0d_busy", i), b2, !tbl[i].exp_err);
      chk($sformatf("v%0d_beats", i), beats.size() - b0, tbl[i].exp_err ? 0 : nbeats(tbl[i].sz));
      chk($sformatf("v%0d_strobes", i), strobe_cnt - s0, tbl[i].exp_err ? 0 : nbeats(tbl[i].sz));
    end
    if (beats.size() == 8) begin
      for (int k = 0; k < 4; k++) chk($sformatf("wl_addr%0d", k), beats[k].addr, 32'h10 + 32'(k));
      chk("hs_addr0", beats[6].addr, 32'h08);
      chk("hs_data0", beats[6].data, 8'h12);
      chk("hs_addr1", beats[7].addr, 32'h09);
      chk("hs_data1", beats[7].data, 8'h34);
    end else begin
      chk("directed_beat_total", beats.size(), 8);
    end
    chk("hs_mem08", mem_arr[8'h08], 8'h12);
    chk("hs_mem09", mem_arr[8'h09], 8'h34);

    // Word store with a three-cycle stall on beat 1
    b0 = beats.size();
    stall_base = beat_count; stall_cyc_base = stall_cycles; stall_en = 1'b1;
    run_op(32'h40, 32'hDEADBEEF, 1'b0, 1'b1, 2'b10, 1'b0, cyc, gd, ge, b2);
    stall_en = 1'b0;
    chk("stall_done", gd, 1'b1);
    chk("stall_cycle", cyc, 9);
    chk("stall_count", stall_cycles - stall_cyc_base, 3);
    chk("stall_readData", readData, 32'h85);
    if (beats.size() - b0 == 4) begin
      chk("stall_b0", {beats[b0].addr, beats[b0].data}, {32'h40, 8'hDE});
      chk("stall_b1", {beats[b0+1].addr, beats[b0+1].data}, {32'h41, 8'hAD});
      chk("stall_b2", {beats[b0+2].addr, beats[b0+2].data}, {32'h42, 8'hBE});
      chk("stall_b3", {beats[b0+3].addr, beats[b0+3].data}, {32'h43, 8'hEF});
    end else begin
      chk("stall_beats", beats.size() - b0, 4);
    end

    // Reset during beat 2 of a word load
    @(negedge clk);
    address = 32'h10; writeData = 0; size = 2'b10; loadSigned = 1'b0; memRead = 1'b1; memWrite = 1'b0;
    b0 = beats.size();
    @(negedge clk);
    memRead = 1'b0;
    for (int i = 0; i < 20 && (beats.size() - b0) < 2; i++) @(negedge clk);
    chk("mid_beat2_addr", mem_if.memAddr, 32'h12);
    chk("mid_beat2_re", mem_if.memRe, 1'b1);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_readData", readData, 32'h0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_strobes", {mem_if.memRe, mem_if.memWe}, 2'b00);
    chk("mid_rst_memAddr", mem_if.memAddr, 32'h0);
    chk("mid_rst_done_err", {done, err}, 2'b00);
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", {mem_if.memRe, mem_if.memWe, busy}, 3'b000);
    end
    run_op(32'h10, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, cyc, gd, ge, b2);
    chk("post_rst_done", gd, 1'b1);
    chk("post_rst_cycle", cyc, 6);
    chk("post_rst_readData", readData, 32'h5);
    exp_rd = 32'h5;

    // Randomized requests against the reference model
    for (int i = 0; i < 256; i++) begin
      mem_arr[i] = 8'($urandom);
      ref_mem[i] = mem_arr[i];
    end
    rand_ready = 1'b1;
    for (int n = 0; n < 80; n++) begin
      ot = $urandom_range(0, 2);
      rd = (ot != 1); wr = (ot != 0);
      sz = 2'($urandom_range(0, 3));
      a = $urandom; wd = $urandom; sg = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        else if (sz == 2'b10) a[1:0] = 2'b00;
      end
      ee = rejected(a, rd, wr, sz);
      nb = nbeats(sz);
      b0 = beats.size();
      run_op(a, wd, rd, wr, sz, sg, cyc, gd, ge, b2);
      chk($sformatf("rnd%0d_err", n), ge, ee);
      chk($sformatf("rnd%0d_done", n), gd, !ee);
      if (ee) begin
        chk($sformatf("rnd%0d_nobeats", n), beats.size() - b0, 0);
      end else begin
        chk($sformatf("rnd%0d_beats", n), beats.size() - b0, nb);
        v = 32'h0;
        for (int k = 0; k < nb; k++) begin
          ak = a + 32'(k);
          if (beats.size() - b0 == nb) begin
            chk($sformatf("rnd%0d_addr%0d", n, k), beats[b0+k].addr, ak);
            if (wr) chk($sformatf("rnd%0d_data%0d", n, k), beats[b0+k].data,
                        8'(wd >> (8 * (nb - 1 - k))));
          end
          if (wr) ref_mem[ak[7:0]] = 8'(wd >> (8 * (nb - 1 - k)));
          else v = (v << 8) | 32'(ref_mem[ak[7:0]]);
        end
        if (rd) begin
          if (nb == 1) v = sg ? 32'($signed(v[7:0])) : {24'h0, v[7:0]};
          else if (nb == 2) v = sg ? 32'($signed(v[15:0])) : {16'h0, v[15:0]};
          exp_rd = v;
        end
      end
      chk($sformatf("rnd%0d_readData", n), readData, exp_rd);
    end
    rand_ready = 1'b0;
    ready_base = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
